melody_seq: RTL

Parametrised, programmable melody sequencer replacing the fixed 20-note prelude player. Holds a writable note table (pitch maxval + duration in samples), plays a selectable-length sequence at a derived sample rate with optional silent articulation gaps, one-shot or looped, under start/stop control. Its `pitch_o` drives the sine `clkgen` maxval and `tone_on` gates the sine/DAC path; sine, DAC and clkgen blocks are unchanged.

---
 rtl/melody_seq.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/melody_seq.sv
// melody_seq -- programmable melody sequencer.
//
// Holds a writable note table ({pitch, duration}) and plays the first seq_len
// entries at a sample rate of clk/FS_DIV, optionally inserting a silent gap of
// GAP_SAMPLES ticks after each note, one-shot or looped.
//
// Ports:
//   clk, reset     system clock, synchronous active-low reset
//   start, stop    playback control (stop wins when both are high)
//   loop_en        wrap to note 0 after the last note (sampled at the wrap point)
//   seq_len        number of notes to play, 1..NUM_NOTES (latched at start)
//   wr_en/addr/... note table write port, usable in any state
//   pitch_o        current pitch maxval for the sine clkgen (0 = rest)
//   tone_on        high while a non-rest note is sounding
//   note_idx       index of the current note
//   busy           high in PLAY or GAP
//   done           one-cycle pulse when a one-shot sequence completes
//   fs_tick        one-cycle sample-rate strobe
module melody_seq #(
    parameter int PITCH_BITWIDTH = 9,
    parameter int DUR_BITWIDTH   = 13,
    parameter int NUM_NOTES      = 32,
    parameter int FS_DIV         = 1250,
    parameter int GAP_SAMPLES    = 200,
    localparam int IDX_W         = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      loop_en,
    input  logic [IDX_W:0]            seq_len,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_addr,
    input  logic [PITCH_BITWIDTH-1:0] wr_pitch,
    input  logic [DUR_BITWIDTH-1:0]   wr_dur,
    output logic [PITCH_BITWIDTH-1:0] pitch_o,
    output logic                      tone_on,
    output logic [IDX_W-1:0]          note_idx,
    output logic                      busy,
    output logic                      done,
    output logic                      fs_tick
);

    localparam int DIV_W    = (FS_DIV > 1) ? $clog2(FS_DIV) : 1;
    localparam int GAP_W    = (GAP_SAMPLES > 1) ? $clog2(GAP_SAMPLES) : 1;
    localparam int GAP_LAST = (GAP_SAMPLES > 0) ? GAP_SAMPLES - 1 : 0;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(FS_DIV - 1);
    localparam logic [IDX_W:0]   LEN_MAX   = (IDX_W + 1)'(NUM_NOTES);

    typedef struct packed {
        logic [PITCH_BITWIDTH-1:0] pitch;
        logic [DUR_BITWIDTH-1:0]   dur;
    } note_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    note_t table_q [NUM_NOTES];

    state_t                    state_q, state_d;
    logic [DIV_W-1:0]          div_q, div_d;
    logic                      fs_tick_q;
    logic [DUR_BITWIDTH-1:0]   dur_ctr_q, dur_ctr_d;
    logic [DUR_BITWIDTH-1:0]   dur_eff_q, dur_eff_d;
    logic [GAP_W-1:0]          gap_ctr_q, gap_ctr_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [IDX_W:0]            len_q, len_d;
    logic [PITCH_BITWIDTH-1:0] pitch_q, pitch_d;
    logic                      tone_q, tone_d;
    logic                      done_q, done_d;

    logic                      adv, load, clear;
    logic [IDX_W-1:0]          load_idx;
    note_t                     rd;

    // Table has no reset: contents survive reset and stop.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_q[wr_addr] <= '{pitch: wr_pitch, dur: wr_dur};
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        dur_ctr_d = dur_ctr_q;
        dur_eff_d = dur_eff_q;
        gap_ctr_d = gap_ctr_q;
        idx_d     = idx_q;
        len_d     = len_q;
        pitch_d   = pitch_q;
        tone_d    = tone_q;
        done_d    = 1'b0;
        adv       = 1'b0;
        load      = 1'b0;
        clear     = 1'b0;
        load_idx  = '0;
        rd        = '0;

        case (state_q)
            IDLE: begin
                if (start && !stop && seq_len != '0 && seq_len <= LEN_MAX) begin
                    len_d    = seq_len;
                    load     = 1'b1;
                    load_idx = '0;
                    // Realign the sample grid so every note lasts whole ticks.
                    div_d    = '0;
                end
            end
            PLAY: begin
                if (stop) begin
                    clear = 1'b1;
                end else if (fs_tick_q) begin
                    if (dur_ctr_q == dur_eff_q - 1'b1) begin
                        if (GAP_SAMPLES > 0) begin
                            state_d   = GAP;
                            tone_d    = 1'b0;
                            gap_ctr_d = '0;
                        end else begin
                            adv = 1'b1;
                        end
                    end else begin
                        dur_ctr_d = dur_ctr_q + 1'b1;
                    end
                end
            end
            GAP: begin
                if (stop) begin
                    clear = 1'b1;
                end else if (fs_tick_q) begin
                    if (gap_ctr_q == GAP_W'(GAP_LAST)) begin
                        adv = 1'b1;
                    end else begin
                        gap_ctr_d = gap_ctr_q + 1'b1;
                    end
                end
            end
            default: clear = 1'b1;
        endcase

        if (adv) begin
            if ({1'b0, idx_q} < len_q - 1'b1) begin
                load     = 1'b1;
                load_idx = idx_q + 1'b1;
            end else if (loop_en) begin
                load     = 1'b1;
                load_idx = '0;
            end else begin
                state_d   = IDLE;
                done_d    = 1'b1;
                pitch_d   = '0;
                tone_d    = 1'b0;
                idx_d     = '0;
                dur_ctr_d = '0;
                gap_ctr_d = '0;
            end
        end

        // Note load latches pitch and duration; later table writes to this
        // entry only take effect at its next load.
        if (load) begin
            rd        = table_q[load_idx];
            state_d   = PLAY;
            idx_d     = load_idx;
            pitch_d   = rd.pitch;
            tone_d    = (rd.pitch != '0);
            dur_eff_d = (rd.dur == '0) ? DUR_BITWIDTH'(1) : rd.dur;
            dur_ctr_d = '0;
        end

        if (clear) begin
            state_d   = IDLE;
            pitch_d   = '0;
            tone_d    = 1'b0;
            idx_d     = '0;
            dur_ctr_d = '0;
            gap_ctr_d = '0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            div_q     <= '0;
            fs_tick_q <= 1'b0;
            dur_ctr_q <= '0;
            dur_eff_q <= '0;
            gap_ctr_q <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            pitch_q   <= '0;
            tone_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            fs_tick_q <= (div_d == DIV_LAST);
            dur_ctr_q <= dur_ctr_d;
            dur_eff_q <= dur_eff_d;
            gap_ctr_q <= gap_ctr_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            pitch_q   <= pitch_d;
            tone_q    <= tone_d;
            done_q    <= done_d;
        end
    end

    assign pitch_o  = pitch_q;
    assign tone_on  = tone_q;
    assign note_idx = idx_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign fs_tick  = fs_tick_q;

endmodule
